// File: rtl/elastic_pipeline_register_pkg.sv
// Shared types for the elastic pipeline register: main-register load select,
// example boundary payload, and occupancy width helper.
package elastic_pipeline_register_pkg;

    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_FROM_IN   = 2'd1,
        MAIN_FROM_SKID = 2'd2
    } main_sel_e;

    // EX/MEM boundary payload; callers size DATA_WIDTH with $bits() of it.
    typedef struct packed {
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [23:0] alu_result;
    } ex_mem_payload_t;

    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/elastic_pipeline_register_skid_stage.sv
// One skid-buffered stage: main + skid registers with valid/ready on both sides.
// Ready is registered so downstream back-pressure never reaches upstream combinationally.
module elastic_pipeline_register_skid_stage
    import elastic_pipeline_register_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [DATA_WIDTH-1:0] r_skid_data;

    logic      w_in_fire;
    logic      w_out_fire;
    logic      w_main_valid_nxt;
    logic      w_skid_valid_nxt;
    logic      w_skid_load;
    main_sel_e w_main_sel;

    assign w_in_fire  = in_valid_i & r_ready & ~flush_i;
    assign w_out_fire = r_main_valid & out_ready_i;

    // Next-state for both valid bits and the data-path steering.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_sel       = MAIN_HOLD;
        w_skid_load      = 1'b0;
        if (w_out_fire) begin
            if (r_skid_valid) begin
                w_main_sel       = MAIN_FROM_SKID;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_main_sel       = MAIN_FROM_IN;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            if (r_main_valid) begin
                w_skid_load      = 1'b1;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_main_sel       = MAIN_FROM_IN;
                w_main_valid_nxt = 1'b1;
            end
        end
        if (flush_i) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk_i) begin
        case (w_main_sel)
            MAIN_FROM_IN:   r_main_data <= in_data_i;
            MAIN_FROM_SKID: r_main_data <= r_skid_data;
            default:        r_main_data <= r_main_data;
        endcase
        if (w_skid_load) begin
            r_skid_data <= in_data_i;
        end
    end

    assign in_ready_o  = r_ready;
    assign out_valid_o = r_main_valid;
    assign out_data_o  = r_main_data;

endmodule

// File: rtl/elastic_pipeline_register.sv
// Chain of STAGES skid stages forming a stallable, flushable pipeline boundary,
// with a registered count of entries held across the chain.
module elastic_pipeline_register
    import elastic_pipeline_register_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned STAGES     = 1,
    localparam int unsigned OCC_WIDTH  = occ_width(STAGES)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [OCC_WIDTH-1:0]  occupancy_o
);

    logic                  w_valid [STAGES+1];
    logic                  w_ready [STAGES+1];
    logic [DATA_WIDTH-1:0] w_data  [STAGES+1];
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [OCC_WIDTH-1:0]  r_occ;

    assign w_valid[0]      = in_valid_i;
    assign w_data[0]       = in_data_i;
    assign w_ready[STAGES] = out_ready_i;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        elastic_pipeline_register_skid_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .flush_i     (flush_i),
            .in_valid_i  (w_valid[g]),
            .in_ready_o  (w_ready[g]),
            .in_data_i   (w_data[g]),
            .out_valid_o (w_valid[g+1]),
            .out_ready_i (w_ready[g+1]),
            .out_data_o  (w_data[g+1])
        );
    end

    assign in_ready_o  = w_ready[0];
    assign out_valid_o = w_valid[STAGES];
    assign out_data_o  = w_data[STAGES];

    // Internal hand-offs keep the total constant; only the end boundaries move it.
    assign w_in_fire  = in_valid_i & w_ready[0] & ~flush_i;
    assign w_out_fire = w_valid[STAGES] & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_WIDTH'(w_in_fire) - OCC_WIDTH'(w_out_fire);
        end
    end

    assign occupancy_o = r_occ;

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Directed + random scoreboard bench for elastic_pipeline_register at STAGES=1,2,3.
module tb_elastic_pipeline_register;
    import elastic_pipeline_register_pkg::*;

    localparam int unsigned DW  = $bits(ex_mem_payload_t);
    localparam int unsigned OW1 = occ_width(1);
    localparam int unsigned OW2 = occ_width(2);
    localparam int unsigned OW3 = occ_width(3);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [DW-1:0]  s1_in_data, s1_out_data;
    logic [OW1-1:0] s1_occ;
    logic           s2_flush, s2_in_valid, s2_in_ready, s2_out_valid, s2_out_ready;
    logic [DW-1:0]  s2_in_data, s2_out_data;
    logic [OW2-1:0] s2_occ;
    logic           s3_flush, s3_in_valid, s3_in_ready, s3_out_valid, s3_out_ready;
    logic [DW-1:0]  s3_in_data, s3_out_data;
    logic [OW3-1:0] s3_occ;

    elastic_pipeline_register #(.DATA_WIDTH(DW), .STAGES(1)) u_s1 (
        .clk_i(clk), .reset_i(reset), .flush_i(s1_flush),
        .in_valid_i(s1_in_valid), .in_ready_o(s1_in_ready), .in_data_i(s1_in_data),
        .out_valid_o(s1_out_valid), .out_ready_i(s1_out_ready), .out_data_o(s1_out_data),
        .occupancy_o(s1_occ));
    elastic_pipeline_register #(.DATA_WIDTH(DW), .STAGES(2)) u_s2 (
        .clk_i(clk), .reset_i(reset), .flush_i(s2_flush),
        .in_valid_i(s2_in_valid), .in_ready_o(s2_in_ready), .in_data_i(s2_in_data),
        .out_valid_o(s2_out_valid), .out_ready_i(s2_out_ready), .out_data_o(s2_out_data),
        .occupancy_o(s2_occ));
    elastic_pipeline_register #(.DATA_WIDTH(DW), .STAGES(3)) u_s3 (
        .clk_i(clk), .reset_i(reset), .flush_i(s3_flush),
        .in_valid_i(s3_in_valid), .in_ready_o(s3_in_ready), .in_data_i(s3_in_data),
        .out_valid_o(s3_out_valid), .out_ready_i(s3_out_ready), .out_data_o(s3_out_data),
        .occupancy_o(s3_occ));

    int n_pass = 0;
    int n_total = 0;
    int d1 = 0, d2 = 0, d3 = 0;
    logic [DW-1:0] q1[$], q2[$], q3[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: pop on each output handshake, then drop held entries on
    // flush/reset or push the accepted input.
    always @(negedge clk) begin
        if (s1_out_valid && s1_out_ready) begin
            check("s1_out_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                check("s1_order", s1_out_data, q1.pop_front());
                d1++;
            end
        end
        if (reset || s1_flush) q1.delete();
        else if (s1_in_valid && s1_in_ready) q1.push_back(s1_in_data);
    end

    always @(negedge clk) begin
        if (s2_out_valid && s2_out_ready) begin
            check("s2_out_expected", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
                check("s2_order", s2_out_data, q2.pop_front());
                d2++;
            end
        end
        if (reset || s2_flush) q2.delete();
        else if (s2_in_valid && s2_in_ready) q2.push_back(s2_in_data);
    end

    always @(negedge clk) begin
        if (s3_out_valid && s3_out_ready) begin
            check("s3_out_expected", 32'(q3.size() > 0), 32'd1);
            if (q3.size() > 0) begin
                check("s3_order", s3_out_data, q3.pop_front());
                d3++;
            end
        end
        if (reset || s3_flush) q3.delete();
        else if (s3_in_valid && s3_in_ready) q3.push_back(s3_in_data);
    end

    initial begin
        int sent;
        int cyc;
        int max_occ;
        int d_before;
        logic acc;

        reset = 1'b1;
        {s1_flush, s1_in_valid, s1_out_ready} = '0;
        {s2_flush, s2_in_valid, s2_out_ready} = '0;
        {s3_flush, s3_in_valid, s3_out_ready} = '0;
        s1_in_data = '0; s2_in_data = '0; s3_in_data = '0;
        repeat (3) step();
        check("rst_s1_out_valid", 32'(s1_out_valid), 32'd0);
        check("rst_s1_in_ready",  32'(s1_in_ready),  32'd1);
        check("rst_s1_occ",       32'(s1_occ),       32'd0);
        check("rst_s2_out_valid", 32'(s2_out_valid), 32'd0);
        check("rst_s2_in_ready",  32'(s2_in_ready),  32'd1);
        check("rst_s3_occ",       32'(s3_occ),       32'd0);
        reset = 1'b0;
        step();

        // Streaming at one per cycle with one-cycle latency.
        s1_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s1_in_valid = 1'b1;
            s1_in_data  = DW'(i);
            step();
            check("t1_out_valid", 32'(s1_out_valid), 32'd1);
            check("t1_out_data",  s1_out_data,       32'(i));
            check("t1_in_ready",  32'(s1_in_ready),  32'd1);
            check("t1_occ",       32'(s1_occ),       32'd1);
        end
        s1_in_valid = 1'b0;
        step();
        check("t1_drained_valid", 32'(s1_out_valid), 32'd0);
        check("t1_drained_occ",   32'(s1_occ),       32'd0);

        // Back-pressure fills main and skid.
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = DW'(32'hA);
        step();
        s1_in_data   = DW'(32'hB);
        step();
        s1_in_valid  = 1'b0;
        check("t2_occ_full",  32'(s1_occ),      32'd2);
        check("t2_in_ready",  32'(s1_in_ready), 32'd0);
        check("t2_hold_data", s1_out_data,      32'hA);
        step();
        step();
        check("t2_stall_stable", s1_out_data,      32'hA);
        check("t2_stall_occ",    32'(s1_occ),      32'd2);
        s1_out_ready = 1'b1;
        step();
        check("t2_second_data", s1_out_data,       32'hB);
        check("t2_in_ready_up", 32'(s1_in_ready),  32'd1);
        check("t2_occ_one",     32'(s1_occ),       32'd1);
        step();
        check("t2_empty_valid", 32'(s1_out_valid), 32'd0);
        check("t2_delivered",   32'(d1),           32'd10);

        // Random valid/ready over 1000 payloads through three stages.
        sent = 0; cyc = 0; max_occ = 0;
        while (sent < 1000 && cyc < 20000) begin
            s3_in_valid  = 1'($urandom_range(0, 1));
            s3_out_ready = 1'($urandom_range(0, 3) != 0 ? ($urandom_range(0, 1)) : 0);
            s3_in_data   = DW'($urandom);
            acc = s3_in_valid & s3_in_ready;
            step();
            if (acc) sent++;
            cyc++;
            if (32'(s3_occ) > max_occ) max_occ = 32'(s3_occ);
            check("t3_occ_vs_model", 32'(s3_occ), 32'(q3.size()));
        end
        s3_in_valid  = 1'b0;
        s3_out_ready = 1'b1;
        check("t3_sent_in_budget", 32'(sent), 32'd1000);
        cyc = 0;
        while (q3.size() > 0 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        check("t3_drained",   32'(q3.size()),      32'd0);
        check("t3_delivered", 32'(d3),             32'(sent));
        check("t3_occ_max",   32'(max_occ <= 6),   32'd1);
        check("t3_final_occ", 32'(s3_occ),         32'd0);

        // Flush with four held entries and a payload presented in the flush cycle.
        s2_out_ready = 1'b0;
        sent = 0; cyc = 0;
        while (sent < 4 && cyc < 20) begin
            s2_in_valid = 1'b1;
            s2_in_data  = DW'(32'h11 + sent);
            acc = s2_in_valid & s2_in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        s2_in_valid = 1'b0;
        check("t4_occ_four", 32'(s2_occ),      32'd4);
        check("t4_full",     32'(s2_in_ready), 32'd0);
        s2_flush    = 1'b1;
        s2_in_valid = 1'b1;
        s2_in_data  = DW'(32'hDEAD);
        step();
        s2_flush    = 1'b0;
        s2_in_valid = 1'b0;
        check("t4_out_valid", 32'(s2_out_valid), 32'd0);
        check("t4_occ",       32'(s2_occ),       32'd0);
        check("t4_in_ready",  32'(s2_in_ready),  32'd1);
        s2_out_ready = 1'b1;
        repeat (4) step();
        check("t4_no_deliver", 32'(d2), 32'd0);

        // Output handshake in the flush cycle counts once; nothing follows.
        s2_in_valid = 1'b1;
        s2_in_data  = DW'(32'h55);
        s2_out_ready = 1'b0;
        step();
        s2_in_valid = 1'b0;
        cyc = 0;
        while (!s2_out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        check("t6_reached_out", 32'(s2_out_valid), 32'd1);
        check("t6_data",        s2_out_data,       32'h55);
        d_before     = d2;
        s2_out_ready = 1'b1;
        s2_flush     = 1'b1;
        s2_in_valid  = 1'b1;
        s2_in_data   = DW'(32'h66);
        step();
        s2_flush    = 1'b0;
        s2_in_valid = 1'b0;
        repeat (4) step();
        check("t6_delivered_once", 32'(d2 - d_before), 32'd1);
        check("t6_empty_after",    32'(s2_out_valid),  32'd0);

        // Reset mid-stall together with flush and a presented payload.
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = DW'(32'hA1);
        step();
        s1_in_data   = DW'(32'hA2);
        step();
        check("t5_stalled_occ", 32'(s1_occ), 32'd2);
        reset       = 1'b1;
        s1_flush    = 1'b1;
        s1_in_data  = DW'(32'hA3);
        step();
        reset       = 1'b0;
        s1_flush    = 1'b0;
        s1_in_valid = 1'b0;
        check("t5_out_valid", 32'(s1_out_valid), 32'd0);
        check("t5_occ",       32'(s1_occ),       32'd0);
        check("t5_in_ready",  32'(s1_in_ready),  32'd1);
        d_before     = d1;
        s1_out_ready = 1'b1;
        repeat (4) step();
        check("t5_no_deliver", 32'(d1 - d_before), 32'd0);
        check("end_q1_empty",  32'(q1.size()),     32'd0);
        check("end_q2_empty",  32'(q2.size()),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
